// File: rtl/bsg_down_pkg.sv
// Shared definitions for the downstream channel receiver: default parameters
// and width helpers used by the top level, the FIFO and the bus interface.
package bsg_down_pkg;

    localparam int DEF_IO_W        = 16;
    localparam int DEF_RATIO       = 2;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_TOKEN_BATCH = 4;
    localparam int DEF_CORE_W      = DEF_IO_W * DEF_RATIO;

    // One extra bit above the index so that full and empty stay distinguishable.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int core_w(input int io_w, input int ratio);
        return io_w * ratio;
    endfunction

endpackage

// File: rtl/bsg_down_channel_rx_if.sv
// Link-side and core-side signals of the downstream channel receiver.
interface bsg_down_channel_rx_if
    import bsg_down_pkg::*;
#(
    parameter int IO_W   = DEF_IO_W,
    parameter int CORE_W = DEF_CORE_W
);
    logic              io_valid_in;
    logic [IO_W-1:0]   io_data_in;
    logic              io_token_out;
    logic              core_valid_out;
    logic [CORE_W-1:0] core_data_out;
    logic              core_ready;
    logic              overflow;

    modport master (
        output io_valid_in, io_data_in, core_ready,
        input  io_token_out, core_valid_out, core_data_out, overflow
    );

    modport slave (
        input  io_valid_in, io_data_in, core_ready,
        output io_token_out, core_valid_out, core_data_out, overflow
    );
endinterface

// File: rtl/bsg_down_fifo.sv
// Circular beat buffer with wrap-bit pointers; drops beats when full and
// records the drop in a sticky overflow flag.
module bsg_down_fifo
    import bsg_down_pkg::*;
#(
    parameter int  WIDTH = DEF_IO_W,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int PW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_req,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [PW-1:0]    count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             full;
    logic             push;

    assign count = wptr - rptr;
    assign full  = (count == PW'(DEPTH));
    assign push  = push_req && !full;
    assign rdata = mem[rptr[PW-2:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            // Full is judged on registered state, so a same-cycle pop does not make room.
            if (push_req && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-2:0]] <= wdata;
    end

endmodule

// File: rtl/bsg_down_channel_rx.sv
// Downstream channel receiver: buffers link beats, packs RATIO of them into a
// core word behind a valid/ready register, and returns batched credit tokens.
module bsg_down_channel_rx
    import bsg_down_pkg::*;
#(
    parameter int IO_W        = DEF_IO_W,
    parameter int RATIO       = DEF_RATIO,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int TOKEN_BATCH = DEF_TOKEN_BATCH
) (
    input  logic                  clk,
    input  logic                  rst,
    bsg_down_channel_rx_if.slave  bus
);

    localparam int CORE_W = core_w(IO_W, RATIO);
    localparam int PW     = ptr_w(DEPTH);
    localparam int LW     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int FW     = $clog2(TOKEN_BATCH + 1);

    logic [IO_W-1:0]   rdata;
    logic [PW-1:0]     occupancy;
    logic              empty;
    logic              pop;
    logic              lane_last;
    logic              out_free;
    logic [LW-1:0]     lane;
    logic [CORE_W-1:0] asm_q;
    logic [CORE_W-1:0] word_next;
    logic              core_valid_q;
    logic [CORE_W-1:0] core_data_q;
    logic              token_q;
    logic [FW-1:0]     freed_cnt;

    bsg_down_fifo #(
        .WIDTH (IO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_req (bus.io_valid_in),
        .wdata    (bus.io_data_in),
        .pop      (pop),
        .rdata    (rdata),
        .count    (occupancy),
        .overflow (bus.overflow)
    );

    assign empty     = (occupancy == '0);
    assign lane_last = (lane == LW'(RATIO - 1));
    assign out_free  = !core_valid_q || bus.core_ready;
    // Lower lanes keep filling under backpressure; only the completing pop waits.
    assign pop       = !empty && (!lane_last || out_free);

    always_comb begin
        word_next = asm_q;
        for (int k = 0; k < RATIO; k++) begin
            if (lane == LW'(k)) word_next[k*IO_W +: IO_W] = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) asm_q <= word_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane         <= '0;
            core_valid_q <= 1'b0;
            core_data_q  <= '0;
            token_q      <= 1'b0;
            freed_cnt    <= '0;
        end else begin
            token_q <= 1'b0;
            if (pop) lane <= lane_last ? '0 : lane + LW'(1);

            if (pop && lane_last) begin
                core_data_q  <= word_next;
                core_valid_q <= 1'b1;
            end else if (bus.core_ready) begin
                core_valid_q <= 1'b0;
            end

            if (pop) begin
                if (freed_cnt == FW'(TOKEN_BATCH - 1)) begin
                    freed_cnt <= '0;
                    token_q   <= 1'b1;
                end else begin
                    freed_cnt <= freed_cnt + FW'(1);
                end
            end
        end
    end

    assign bus.core_valid_out = core_valid_q;
    assign bus.core_data_out  = core_data_q;
    assign bus.io_token_out   = token_q;

endmodule

// File: tb/tb_bsg_down_channel_rx.sv
// Directed self-checking bench for bsg_down_channel_rx at default parameters.
module tb_bsg_down_channel_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    bsg_down_channel_rx_if #(.IO_W(16), .CORE_W(32)) bus ();

    bsg_down_channel_rx #(
        .IO_W(16), .RATIO(2), .DEPTH(64), .TOKEN_BATCH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.io_valid_in = 1'b0;
        bus.io_data_in  = '0;
        bus.core_ready  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.core_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.core_valid_out); end
        n_checks++; if (bus.core_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", bus.core_data_out); end
        n_checks++; if (bus.io_token_out !== 1'b0) begin n_fail++; $display("FAIL reset_token: got %b expected 0", bus.io_token_out); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        n_checks++; if (dut.occupancy !== 7'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", dut.occupancy); end
    endtask

    task automatic test_basic();
        do_reset();
        bus.core_ready  = 1'b1;
        bus.io_valid_in = 1'b1;
        bus.io_data_in  = 16'h1111;
        step();
        n_checks++; if (bus.core_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early1: got %b expected 0", bus.core_valid_out); end
        bus.io_data_in = 16'h2222;
        step();
        n_checks++; if (bus.core_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_early2: got %b expected 0", bus.core_valid_out); end
        bus.io_valid_in = 1'b0;
        step();
        n_checks++; if (bus.core_valid_out !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", bus.core_valid_out); end
        n_checks++; if (bus.core_data_out !== 32'h22221111) begin n_fail++; $display("FAIL basic_data: got %h expected 22221111", bus.core_data_out); end
        step();
        n_checks++; if (bus.core_valid_out !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b expected 0", bus.core_valid_out); end
    endtask

    task automatic test_backpressure();
        int nw;
        logic [31:0] exp_w;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.io_valid_in = 1'b1;
            bus.io_data_in  = 16'h0100 + 16'(i);
            step();
        end
        bus.io_valid_in = 1'b0;
        // Two entries sit in the output word and one in lane 0: 8 - 3 remain.
        n_checks++; if (dut.occupancy !== 7'd5) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected 5", dut.occupancy); end
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (bus.core_valid_out !== 1'b1 || bus.core_data_out !== 32'h01010100) begin
                n_fail++; $display("FAIL bp_hold: got v=%b d=%h expected v=1 d=01010100", bus.core_valid_out, bus.core_data_out);
            end
            step();
        end
        n_checks++; if (dut.occupancy !== 7'd5) begin n_fail++; $display("FAIL bp_occupancy_hold: got %0d expected 5", dut.occupancy); end
        bus.core_ready = 1'b1;
        nw = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.core_valid_out === 1'b1) begin
                exp_w = {16'h0100 + 16'(2*nw + 1), 16'h0100 + 16'(2*nw)};
                n_checks++; if (bus.core_data_out !== exp_w) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", nw, bus.core_data_out, exp_w); end
                nw++;
            end
            step();
        end
        n_checks++; if (nw !== 4) begin n_fail++; $display("FAIL bp_word_count: got %0d expected 4", nw); end
        n_checks++; if (dut.occupancy !== 7'd0) begin n_fail++; $display("FAIL bp_drained: got %0d expected 0", dut.occupancy); end
    endtask

    task automatic test_overflow();
        int nw;
        logic [31:0] exp_w;
        do_reset();
        // Three entries leave the buffer for the output register and lane 0,
        // so 67 beats are accepted before the buffer is full.
        for (int i = 0; i < 67; i++) begin
            bus.io_valid_in = 1'b1;
            bus.io_data_in  = 16'h1000 + 16'(i);
            step();
        end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b expected 0", bus.overflow); end
        n_checks++; if (dut.occupancy !== 7'd64) begin n_fail++; $display("FAIL ovf_full: got %0d expected 64", dut.occupancy); end
        bus.io_data_in = 16'hBEEF;
        step();
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
        n_checks++; if (dut.occupancy !== 7'd64) begin n_fail++; $display("FAIL ovf_still_full: got %0d expected 64", dut.occupancy); end
        // First pop while full coincides with a push that must be dropped.
        bus.core_ready  = 1'b1;
        bus.io_data_in  = 16'hDEAD;
        nw = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.core_valid_out === 1'b1) begin
                exp_w = {16'h1000 + 16'(2*nw + 1), 16'h1000 + 16'(2*nw)};
                n_checks++;
                if (nw >= 33 || bus.core_data_out !== exp_w) begin
                    n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", nw, bus.core_data_out, exp_w);
                end
                nw++;
            end
            step();
            bus.io_valid_in = 1'b0;
        end
        n_checks++; if (nw !== 33) begin n_fail++; $display("FAIL ovf_word_count: got %0d expected 33", nw); end
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
        n_checks++; if (dut.occupancy !== 7'd0) begin n_fail++; $display("FAIL ovf_drained: got %0d expected 0", dut.occupancy); end
    endtask

    task automatic test_tokens();
        int npulse;
        int nw;
        logic exp_tok;
        logic [31:0] exp_w;
        do_reset();
        bus.core_ready = 1'b1;
        npulse = 0;
        nw = 0;
        for (int n = 0; n < 30; n++) begin
            exp_tok = (n == 5 || n == 9 || n == 13 || n == 17);
            n_checks++; if (bus.io_token_out !== exp_tok) begin n_fail++; $display("FAIL tok_cycle%0d: got %b expected %b", n, bus.io_token_out, exp_tok); end
            if (bus.io_token_out === 1'b1) npulse++;
            if (bus.core_valid_out === 1'b1) begin
                exp_w = {16'h2000 + 16'(2*nw + 1), 16'h2000 + 16'(2*nw)};
                n_checks++; if (bus.core_data_out !== exp_w) begin n_fail++; $display("FAIL tok_word%0d: got %h expected %h", nw, bus.core_data_out, exp_w); end
                nw++;
            end
            bus.io_valid_in = (n < 16);
            bus.io_data_in  = 16'h2000 + 16'(n);
            step();
        end
        n_checks++; if (npulse !== 4) begin n_fail++; $display("FAIL tok_pulses: got %0d expected 4", npulse); end
        n_checks++; if (nw !== 8) begin n_fail++; $display("FAIL tok_words: got %0d expected 8", nw); end
    endtask

    task automatic test_wrap();
        int nw;
        int ntok;
        logic [15:0] lo, hi;
        do_reset();
        bus.core_ready = 1'b1;
        nw = 0;
        ntok = 0;
        for (int n = 0; n < 220; n++) begin
            if (bus.io_token_out === 1'b1) ntok++;
            if (bus.core_valid_out === 1'b1) begin
                lo = 16'((2*nw) * 3 + 7);
                hi = 16'((2*nw + 1) * 3 + 7);
                n_checks++; if (bus.core_data_out !== {hi, lo}) begin n_fail++; $display("FAIL wrap_word%0d: got %h expected %h", nw, bus.core_data_out, {hi, lo}); end
                nw++;
            end
            bus.io_valid_in = (n < 200);
            bus.io_data_in  = 16'(n * 3 + 7);
            step();
        end
        n_checks++; if (nw !== 100) begin n_fail++; $display("FAIL wrap_words: got %0d expected 100", nw); end
        n_checks++; if (ntok !== 50) begin n_fail++; $display("FAIL wrap_tokens: got %0d expected 50", ntok); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL wrap_overflow: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_reset_mid();
        int nw;
        int ntok;
        logic [31:0] got_w;
        do_reset();
        bus.core_ready  = 1'b1;
        bus.io_valid_in = 1'b1;
        bus.io_data_in  = 16'h5555;
        step();
        rst = 1'b1;
        bus.io_valid_in = 1'b0;
        step();
        rst = 1'b0;
        n_checks++; if (bus.core_valid_out !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", bus.core_valid_out); end
        n_checks++; if (bus.core_data_out !== 32'h0) begin n_fail++; $display("FAIL rmid_data: got %h expected 00000000", bus.core_data_out); end
        n_checks++; if (bus.io_token_out !== 1'b0) begin n_fail++; $display("FAIL rmid_token: got %b expected 0", bus.io_token_out); end
        n_checks++; if (dut.occupancy !== 7'd0) begin n_fail++; $display("FAIL rmid_occupancy: got %0d expected 0", dut.occupancy); end
        bus.io_valid_in = 1'b1;
        bus.io_data_in  = 16'hAAAA;
        step();
        bus.io_data_in  = 16'hBBBB;
        step();
        bus.io_valid_in = 1'b0;
        nw = 0;
        ntok = 0;
        got_w = '0;
        for (int c = 0; c < 8; c++) begin
            if (bus.io_token_out === 1'b1) ntok++;
            if (bus.core_valid_out === 1'b1) begin got_w = bus.core_data_out; nw++; end
            step();
        end
        n_checks++; if (nw !== 1) begin n_fail++; $display("FAIL rmid_word_count: got %0d expected 1", nw); end
        n_checks++; if (got_w !== 32'hBBBBAAAA) begin n_fail++; $display("FAIL rmid_word: got %h expected bbbbaaaa", got_w); end
        n_checks++; if (ntok !== 0) begin n_fail++; $display("FAIL rmid_no_token: got %0d expected 0", ntok); end
    endtask

    initial begin
        bus.io_valid_in = 1'b0;
        bus.io_data_in  = '0;
        bus.core_ready  = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_tokens();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
